// File: rtl/fifo_arb_ctrl.sv
// Round-robin write arbiter and occupancy tracker in front of a synchronous FIFO.
// Grants and read acknowledges are combinational; occupancy, grant pointer and rd_valid are registered.
module fifo_arb_ctrl #(
  parameter int NREQ  = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DW-1:0]         req_data,
  output logic [NREQ-1:0]            gnt,
  input  logic                       rd_req,
  output logic                       rd_ack,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       fifo_cs,
  output logic                       fifo_wr_en,
  output logic                       fifo_rd_en,
  output logic [DW-1:0]              fifo_din,
  input  logic                       fifo_full
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  logic [IW-1:0] last_gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic          wr_elig;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Saturating occupancy update; simultaneous read and write cancel out.
  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cur,
                                               input logic wr, input logic rd);
    logic [CW-1:0] nxt;
    nxt = cur;
    if (wr && !rd && cur != DEPTH_C) nxt = cur + CW'(1);
    if (rd && !wr && cur != '0)      nxt = cur - CW'(1);
    return nxt;
  endfunction

  // Arbitration: search upward from the slot after the last winner, with wrap.
  always_comb begin
    wr_elig = (count < DEPTH_C) && !fifo_full && !rst;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (wr_elig) begin
      for (int off = 1; off <= NREQ; off++) begin
        if (!gnt_any && req[wrap_idx(last_gnt, off)]) begin
          gnt_any = 1'b1;
          gnt_idx = wrap_idx(last_gnt, off);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    fifo_din = gnt_any ? req_data[int'(gnt_idx)*DW +: DW] : '0;
  end

  assign fifo_wr_en = gnt_any;
  assign rd_ack     = rd_req && (count != '0) && !rst;
  assign fifo_rd_en = rd_ack;
  assign fifo_cs    = fifo_wr_en || fifo_rd_en;

  // State update at the clock edge; rd_valid marks the cycle the FIFO output is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      last_gnt <= LAST_RST;
      rd_valid <= 1'b0;
    end else begin
      count    <= next_count(count, gnt_any, rd_ack);
      rd_valid <= rd_ack;
      if (gnt_any) last_gnt <= gnt_idx;
    end
  end

endmodule
